led_seq_ctrl: RTL
=================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000: clock cycles per display phase (>=2).
REQ-002 SHALL have parameter RESET_TICKS, default 4: phases the reset code is shown (>=1).
REQ-003 SHALL have parameter BLINK_COUNT, default 3: on/off blink pairs per score update (>=1).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port score_in, input, 7: new score value.
REQ-007 SHALL have port score_valid, input, 1: one-cycle strobe qualifying score_in.
REQ-008 SHALL have port game_reset, input, 1: request to re-show the reset code and clear the score.
REQ-009 SHALL have port score_out, output, 7: registered score feeding the LED mux.
REQ-010 SHALL have port leds_ctrl, output, 2: registered mux select (0 ALL_OFF, 1 ALL_ON, 2 RESET_CODE, 3 SCORE).
REQ-011 SHALL have port busy, output, 1: high in every state except S_SCORE.

Function
REQ-012 SHALL implement four states: S_RESET_SHOW (leds_ctrl=2), S_SCORE (3), S_BLINK_ON (1), S_BLINK_OFF (0).
REQ-013 SHALL derive a phase tick every TICK_DIV cycles; the tick counter restarts at 0 on every state transition, so each phase lasts exactly TICK_DIV cycles.
REQ-014 S_RESET_SHOW SHALL last RESET_TICKS phases, then go to S_SCORE.
REQ-015 In S_SCORE, score_valid SHALL load score_out from score_in on the next edge and (macro set) enter S_BLINK_ON with the blink counter = BLINK_COUNT.
REQ-016 S_BLINK_ON SHALL go to S_BLINK_OFF after one phase; S_BLINK_OFF SHALL decrement the counter and go to S_BLINK_ON, or to S_SCORE when the counter reaches 0.
REQ-017 score_valid in either blink state SHALL load score_out and restart blinking from S_BLINK_ON with a full BLINK_COUNT.
REQ-018 score_valid in S_RESET_SHOW SHALL load score_out only; the state and phase timing are unchanged.
REQ-019 game_reset SHALL, from any state, enter S_RESET_SHOW, clear score_out to 0 and restart the tick counter; it overrides a simultaneous score_valid, which is discarded.
REQ-020 All outputs SHALL be registered; leds_ctrl, score_out and busy change exactly one cycle after the causing input or tick.
REQ-021 score_out SHALL be transferred unmodified, with no arithmetic or saturation.

Reset
REQ-022 rst SHALL force S_RESET_SHOW, leds_ctrl=2, score_out=0, busy=1, and clear the tick and blink counters.
REQ-023 rst SHALL take priority over game_reset and score_valid, including mid-blink and mid-reset-show.

Configuration
REQ-024 Macro LED_SEQ_BLINK_EN defined SHALL compile in the blink states and blink counter, behaving per REQ-015..017.
REQ-025 Without LED_SEQ_BLINK_EN, score_valid SHALL only load score_out, the FSM SHALL never leave S_SCORE on score_valid, and leds_ctrl values 0/1 are never produced.

Structure
REQ-026 The shared package led_pkg SHALL hold the leds_ctrl codes (LED_ALL_OFF, LED_ALL_ON, LED_RESET_CODE, LED_SCORE) and the state enum type.
REQ-027 The phase divider SHALL be the sub-module led_tick_gen (inputs clk, rst, restart; output tick).

Verification (TICK_DIV=4, RESET_TICKS=2, BLINK_COUNT=2)
REQ-028 Release rst -> leds_ctrl=2, busy=1 for 8 cycles, then leds_ctrl=3, score_out=0, busy=0.
REQ-029 Macro set, in S_SCORE pulse score_valid with score_in=42 -> next cycle score_out=42; leds_ctrl sequence 1,0,1,0 for 4 cycles each, then 3, busy=0.
REQ-030 Macro unset, same stimulus -> score_out=42 next cycle; leds_ctrl stays 3; busy stays 0.
REQ-031 game_reset and score_valid (score_in=99) in the same cycle in S_SCORE -> next cycle leds_ctrl=2, score_out=0; after 8 cycles leds_ctrl=3 with score_out=0.
REQ-032 Assert rst during S_BLINK_OFF -> next cycle leds_ctrl=2, score_out=0; after release, the full 8-cycle reset show occurs.
REQ-033 score_valid (score_in=7) during the second S_BLINK_ON -> score_out=7, and the blink restarts with two full on/off pairs before leds_ctrl=3.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer: mux select codes, FSM state type
// and the state-to-select mapping.
package led_pkg;

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned LED_W   = 2;

  localparam logic [LED_W-1:0] LED_ALL_OFF    = 2'd0;
  localparam logic [LED_W-1:0] LED_ALL_ON     = 2'd1;
  localparam logic [LED_W-1:0] LED_RESET_CODE = 2'd2;
  localparam logic [LED_W-1:0] LED_SCORE      = 2'd3;

  typedef enum logic [1:0] {
    S_RESET_SHOW,
    S_SCORE,
    S_BLINK_ON,
    S_BLINK_OFF
  } state_e;

  // Each state drives exactly one mux select code.
  function automatic logic [LED_W-1:0] led_code(input state_e s);
    logic [LED_W-1:0] code;
    case (s)
      S_RESET_SHOW: code = LED_RESET_CODE;
      S_SCORE:      code = LED_SCORE;
      S_BLINK_ON:   code = LED_ALL_ON;
      S_BLINK_OFF:  code = LED_ALL_OFF;
      default:      code = LED_RESET_CODE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Phase divider: registered one-cycle tick every TICK_DIV cycles; restart
// realigns the phase so the next tick arrives exactly TICK_DIV cycles later.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(TICK_DIV - 2);

  logic [CW-1:0] cnt;

  // tick is registered, so it is raised one count early to land on CNT_LAST.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_PRE);
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED display sequencer: reset-code show, score display and optional blink
// acknowledgement of score updates (enabled by macro LED_SEQ_BLINK_EN).
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned RESET_TICKS = 4,
  parameter int unsigned BLINK_COUNT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  input  logic               game_reset,
  output logic [SCORE_W-1:0] score_out,
  output logic [LED_W-1:0]   leds_ctrl,
  output logic               busy
);

  localparam int unsigned PW = (RESET_TICKS > 1) ? $clog2(RESET_TICKS) : 1;

  if (TICK_DIV < 2 || RESET_TICKS < 1 || BLINK_COUNT < 1) begin : g_param_check
    $error("led_seq_ctrl: TICK_DIV must be >= 2, RESET_TICKS and BLINK_COUNT >= 1");
  end

  state_e             state;
  state_e             state_n;
  logic [PW-1:0]      phase_cnt;
  logic [PW-1:0]      phase_n;
  logic [SCORE_W-1:0] score_n;
  logic               tick;
  logic               reload_c;
  logic               restart_c;

`ifdef LED_SEQ_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_COUNT + 1);
  localparam logic [BW-1:0] BLINK_FULL = BW'(BLINK_COUNT);

  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_n;
`endif

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_c),
    .tick    (tick)
  );

  // Next-state logic; game_reset wins over any simultaneous score_valid.
  always_comb begin
    state_n  = state;
    score_n  = score_out;
    phase_n  = phase_cnt;
    reload_c = 1'b0;
`ifdef LED_SEQ_BLINK_EN
    blink_n  = blink_cnt;
`endif
    if (game_reset) begin
      state_n  = S_RESET_SHOW;
      score_n  = '0;
      phase_n  = '0;
      reload_c = 1'b1;
    end else begin
      if (score_valid) begin
        score_n = score_in;
      end
      case (state)
        S_RESET_SHOW: begin
          if (tick) begin
            if (phase_cnt == PW'(RESET_TICKS - 1)) begin
              state_n = S_SCORE;
              phase_n = '0;
            end else begin
              phase_n = phase_cnt + PW'(1);
            end
          end
        end
`ifdef LED_SEQ_BLINK_EN
        S_SCORE: begin
          if (score_valid) begin
            state_n = S_BLINK_ON;
            blink_n = BLINK_FULL;
          end
        end
        S_BLINK_ON: begin
          if (score_valid) begin
            blink_n  = BLINK_FULL;
            reload_c = 1'b1;
          end else if (tick) begin
            state_n = S_BLINK_OFF;
          end
        end
        S_BLINK_OFF: begin
          if (score_valid) begin
            state_n  = S_BLINK_ON;
            blink_n  = BLINK_FULL;
            reload_c = 1'b1;
          end else if (tick) begin
            blink_n = blink_cnt - BW'(1);
            state_n = (blink_cnt == BW'(1)) ? S_SCORE : S_BLINK_ON;
          end
        end
        default: state_n = S_RESET_SHOW;
`else
        S_SCORE: state_n = S_SCORE;
        default: state_n = S_SCORE;
`endif
      endcase
    end
    // Every state change (or blink reload) realigns the phase divider.
    restart_c = reload_c || (state_n != state);
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET_SHOW;
      leds_ctrl <= LED_RESET_CODE;
      score_out <= '0;
      busy      <= 1'b1;
      phase_cnt <= '0;
`ifdef LED_SEQ_BLINK_EN
      blink_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      leds_ctrl <= led_code(state_n);
      score_out <= score_n;
      busy      <= (state_n != S_SCORE);
      phase_cnt <= phase_n;
`ifdef LED_SEQ_BLINK_EN
      blink_cnt <= blink_n;
`endif
    end
  end

endmodule
